// File: rtl/mining_job_loader_pkg.sv
// rtl/mining_job_loader_pkg.sv - shared widths, header default and state encoding for the job loader
package mining_job_loader_pkg;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
    localparam int         BLOCK_BYTES      = 12;
    localparam int         TARGET_W         = 8;
    localparam int         BLOCK_W          = 8 * BLOCK_BYTES;
    localparam int         NONCE_W          = 32;

    typedef enum logic [6:0] {
        ST_HDR    = 7'b000_0001,
        ST_TGT    = 7'b000_0010,
        ST_BLK    = 7'b000_0100,
        ST_CHK    = 7'b000_1000,
        ST_LAUNCH = 7'b001_0000,
        ST_WAIT   = 7'b010_0000,
        ST_ABORT  = 7'b100_0000
    } state_e;

endpackage

// File: rtl/mining_job_loader.sv
// rtl/mining_job_loader.sv - frames a job byte stream, launches the nonce engine, collects its result
module mining_job_loader
    import mining_job_loader_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEFAULT,
    parameter logic [31:0] TIMEOUT    = 32'd0,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [TARGET_W-1:0] target,
    output logic [BLOCK_W-1:0]  block,
    output logic                start,
    output logic                miner_rst,
    input  logic                terminado,
    input  logic [NONCE_W-1:0]  nonce_in,
    output logic [NONCE_W-1:0]  job_nonce,
    output logic                job_done,
    output logic                job_err,
    output logic                job_timeout,
    output logic                busy
);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [7:0]           chk_q, chk_d;
    logic [31:0]          tmo_q, tmo_d;
    logic [TARGET_W-1:0]  target_q, target_d;
    logic [BLOCK_W-1:0]   block_q, block_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic                 rx_ready_q, rx_ready_d;
    logic                 start_q, start_d;
    logic                 miner_rst_q, miner_rst_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 tmo_pulse_q, tmo_pulse_d;
    logic                 busy_q, busy_d;
    logic                 xfer;

    assign xfer = rx_valid & rx_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        tmo_d       = tmo_q;
        target_d    = target_q;
        block_d     = block_q;
        nonce_d     = nonce_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        tmo_pulse_d = 1'b0;

        unique case (state_q)
            ST_HDR: begin
                if (xfer && rx_data == HDR_BYTE) begin
                    chk_d   = '0;
                    state_d = ST_TGT;
                end
            end
            ST_TGT: begin
                if (xfer) begin
                    target_d = rx_data;
                    chk_d    = chk_q ^ rx_data;
                    cnt_d    = '0;
                    state_d  = ST_BLK;
                end
            end
            ST_BLK: begin
                if (xfer) begin
                    for (int k = 0; k < BLOCK_BYTES; k++) begin
                        if (cnt_q == 4'(k)) block_d[BLOCK_W-1-8*k -: 8] = rx_data;
                    end
                    chk_d = chk_q ^ rx_data;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(BLOCK_BYTES - 1)) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    if (rx_data == chk_q) begin
                        state_d = ST_LAUNCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_HDR;
                    end
                end
            end
            ST_LAUNCH: begin
                start_d = 1'b1;
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the expiry cycle still counts as a completed job.
                if (terminado) begin
                    nonce_d = nonce_in;
                    done_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_ABORT;
                end else if (TIMEOUT != 32'd0 && tmo_q == TIMEOUT - 32'd1) begin
                    tmo_pulse_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = ST_ABORT;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            ST_ABORT: begin
                // The timeout counter is reused here to length the engine re-arm pulse.
                if (tmo_q + 32'd1 >= 32'(RST_CYCLES)) begin
                    tmo_d   = '0;
                    state_d = ST_HDR;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            default: state_d = ST_HDR;
        endcase

        rx_ready_d  = (state_d == ST_HDR) || (state_d == ST_TGT) ||
                      (state_d == ST_BLK) || (state_d == ST_CHK);
        miner_rst_d = (state_d == ST_ABORT);
        busy_d      = (state_d != ST_HDR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HDR;
            cnt_q       <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            target_q    <= '0;
            block_q     <= '0;
            nonce_q     <= '0;
            rx_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            miner_rst_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tmo_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            target_q    <= target_d;
            block_q     <= block_d;
            nonce_q     <= nonce_d;
            rx_ready_q  <= rx_ready_d;
            start_q     <= start_d;
            miner_rst_q <= miner_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
            tmo_pulse_q <= tmo_pulse_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign target      = target_q;
    assign block       = block_q;
    assign start       = start_q;
    assign miner_rst   = miner_rst_q;
    assign job_nonce   = nonce_q;
    assign job_done    = done_q;
    assign job_err     = err_q;
    assign job_timeout = tmo_pulse_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mining_job_loader.sv
// tb/tb_mining_job_loader.sv - randomized frame stimulus against a frame-level model and engine stand-in
module tb_mining_job_loader;

    localparam logic [7:0] HDR  = 8'hA5;
    localparam int         TMO  = 50;
    localparam int         RSTC = 2;
    localparam int         K_ERR = 0, K_JOB = 1, K_TMO = 2;

    logic        clk = 1'b0;
    logic        reset, rx_valid, rx_ready, start, miner_rst, terminado;
    logic        job_done, job_err, job_timeout, busy;
    logic [7:0]  rx_data, target;
    logic [95:0] block;
    logic [31:0] nonce_in, job_nonce;

    always #5 clk = ~clk;

    mining_job_loader #(
        .HDR_BYTE   (HDR),
        .TIMEOUT    (32'(TMO)),
        .RST_CYCLES (RSTC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .target      (target),
        .block       (block),
        .start       (start),
        .miner_rst   (miner_rst),
        .terminado   (terminado),
        .nonce_in    (nonce_in),
        .job_nonce   (job_nonce),
        .job_done    (job_done),
        .job_err     (job_err),
        .job_timeout (job_timeout),
        .busy        (busy)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;
    int n_start, n_done, n_err, n_tmo, n_mrst, bad_acc;
    int start_cyc, done_cyc, err_cyc, tmo_cyc, mrst_first, busy_fall, term_cyc, xfer_cyc;
    logic        busy_prev, rdy_after, eng_run;
    int          eng_cnt;
    logic [31:0] exp_nonce;
    logic [7:0]  stream_q[$];

    function automatic int eng_delay(input logic [7:0] t);
        return 2 + int'(~t & 8'h1F);
    endfunction

    function automatic logic [31:0] eng_nonce(input logic [7:0] t, input logic [95:0] b);
        return b[31:0] ^ {b[95:88], 16'h5A5A, t};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_start = 0; n_done = 0; n_err = 0; n_tmo = 0; n_mrst = 0; bad_acc = 0;
        start_cyc = -1; done_cyc = -1; err_cyc = -1; tmo_cyc = -1;
        mrst_first = -1; busy_fall = -1; term_cyc = -1;
    endtask

    // One clock: observe pulses just after the edge, then step the engine stand-in.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (start)       begin n_start++; start_cyc = cyc; end
        if (job_done)    begin n_done++;  done_cyc  = cyc; end
        if (job_err)     begin n_err++;   err_cyc   = cyc; end
        if (job_timeout) begin n_tmo++;   tmo_cyc   = cyc; end
        if (miner_rst)   begin if (n_mrst == 0) mrst_first = cyc; n_mrst++; end
        if (busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
        if (reset || miner_rst) begin
            eng_run = 1'b0; terminado = 1'b0; eng_cnt = 0;
        end else if (start) begin
            eng_run = 1'b1; eng_cnt = 0;
        end else if (eng_run && !terminado && target != 8'h00) begin
            eng_cnt++;
            if (eng_cnt == eng_delay(target)) begin
                terminado = 1'b1;
                nonce_in  = eng_nonce(target, block);
                term_cyc  = cyc;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit jitter);
        bit acc = 1'b0;
        int guard = 0;
        while (!acc) begin
            rx_valid = jitter ? ($urandom_range(0, 2) != 0) : 1'b1;
            rx_data  = rx_valid ? b : 8'($urandom);
            acc      = rx_valid && rx_ready;
            tick();
            guard++;
            if (!acc && guard > 200) begin
                check_eq("rx_accept_bound", rx_ready, 1'b1);
                acc = 1'b1;
            end
        end
        rx_valid  = 1'b0;
        xfer_cyc  = cyc;
        rdy_after = rx_ready;
    endtask

    // While the loader is busy with a job, keep offering bytes; none may be taken.
    task automatic wait_idle();
        int g = 0;
        while (busy && g < 400) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom_range(0, 164));
            if (rx_ready) bad_acc++;
            tick();
            g++;
        end
        rx_valid = 1'b0;
        check_eq("idle_bound", busy, 1'b0);
    endtask

    task automatic build_frame(input int n_garb, input logic [7:0] t, input logic [95:0] b,
                               input logic [8:0] chk_ovr);
        logic [7:0] x;
        x = t;
        repeat (n_garb) stream_q.push_back(8'($urandom_range(0, 164)));
        stream_q.push_back(HDR);
        stream_q.push_back(t);
        for (int k = 0; k < 12; k++) begin
            stream_q.push_back(b[95-8*k -: 8]);
            x ^= b[95-8*k -: 8];
        end
        stream_q.push_back(chk_ovr[8] ? chk_ovr[7:0] : x);
    endtask

    task automatic model_parse(output int kind, output logic [7:0] t, output logic [95:0] b);
        int i = 0;
        logic [7:0] x;
        while (i < stream_q.size() && stream_q[i] != HDR) i++;
        t = stream_q[i+1];
        x = t;
        b = '0;
        for (int k = 0; k < 12; k++) begin
            b = {b[87:0], stream_q[i+2+k]};
            x ^= stream_q[i+2+k];
        end
        kind = (stream_q[i+14] != x) ? K_ERR : ((t == 8'h00) ? K_TMO : K_JOB);
    endtask

    task automatic run_case(input string name, input bit jitter);
        int kind;
        logic [7:0]  t;
        logic [95:0] b;
        clear_mon();
        model_parse(kind, t, b);
        foreach (stream_q[j]) send_byte(stream_q[j], jitter);
        wait_idle();
        stream_q.delete();
        check_eq({name, ".target"},  target, t);
        check_eq({name, ".block"},   block, b);
        check_eq({name, ".bad_acc"}, bad_acc, 0);
        check_eq({name, ".n_start"}, n_start, kind != K_ERR);
        if (kind == K_ERR) begin
            check_eq({name, ".n_err"},     n_err, 1);
            check_eq({name, ".err_cyc"},   err_cyc, xfer_cyc);
            check_eq({name, ".rdy_after"}, rdy_after, 1'b1);
            check_eq({name, ".busy_fall"}, busy_fall, xfer_cyc);
            check_eq({name, ".others"},    {n_done, n_tmo, n_mrst}, 96'h0);
            check_eq({name, ".nonce"},     job_nonce, exp_nonce);
        end else begin
            check_eq({name, ".start_cyc"}, start_cyc, xfer_cyc + 1);
            check_eq({name, ".rdy_after"}, rdy_after, 1'b0);
            check_eq({name, ".n_err"},     n_err, 0);
            check_eq({name, ".n_mrst"},    n_mrst, RSTC);
            if (kind == K_JOB) begin
                exp_nonce = eng_nonce(t, b);
                check_eq({name, ".n_done"},    n_done, 1);
                check_eq({name, ".n_tmo"},     n_tmo, 0);
                check_eq({name, ".done_cyc"},  done_cyc, term_cyc + 1);
                check_eq({name, ".nonce"},     job_nonce, exp_nonce);
                check_eq({name, ".mrst_cyc"},  mrst_first, done_cyc);
                check_eq({name, ".busy_fall"}, busy_fall, done_cyc + RSTC);
            end else begin
                check_eq({name, ".n_tmo"},     n_tmo, 1);
                check_eq({name, ".n_done"},    n_done, 0);
                check_eq({name, ".tmo_cyc"},   tmo_cyc, start_cyc + TMO);
                check_eq({name, ".nonce"},     job_nonce, exp_nonce);
                check_eq({name, ".mrst_cyc"},  mrst_first, tmo_cyc);
                check_eq({name, ".busy_fall"}, busy_fall, tmo_cyc + RSTC);
            end
        end
    endtask

    task automatic check_rst(input string name);
        check_eq({name, ".block"}, block, 96'h0);
        check_eq({name, ".outs"},
                 {rx_ready, target, start, miner_rst, job_nonce, job_done, job_err, job_timeout, busy},
                 {1'b1, 46'h0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] t;
        bit         bad;
        int         g;
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; terminado = 1'b0; nonce_in = '0;
        eng_run = 1'b0; eng_cnt = 0; busy_prev = 1'b0; exp_nonce = '0;
        clear_mon();
        tick();
        tick();
        check_rst("reset");
        reset = 1'b0;
        tick();

        build_frame(0, 8'hFF, 96'h0, 9'h000);
        run_case("t1_loose", 1'b0);

        build_frame(0, 8'h10, 96'h000102030405060708090A0B, {1'b1, 8'h00});
        run_case("t2_badchk", 1'b0);

        stream_q.push_back(8'h00);
        stream_q.push_back(8'h11);
        stream_q.push_back(8'hA4);
        build_frame(0, 8'h3C, {$urandom, $urandom, $urandom}, 9'h000);
        run_case("t3_garbage", 1'b0);

        build_frame(0, 8'h00, {$urandom, $urandom, $urandom}, 9'h000);
        run_case("t4_timeout", 1'b0);
        build_frame(0, 8'h7E, {$urandom, $urandom, $urandom}, 9'h000);
        run_case("t4_after", 1'b0);

        for (int r = 0; r < 10; r++) begin
            t   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            build_frame($urandom_range(0, 3), t, {$urandom, $urandom, $urandom},
                        bad ? {1'b1, 8'($urandom)} : 9'h000);
            run_case($sformatf("t5_rand%0d", r), 1'b1);
        end

        // Reset while still collecting block bytes.
        build_frame(0, 8'h55, {$urandom, $urandom, $urandom}, 9'h000);
        for (int j = 0; j < 7; j++) send_byte(stream_q[j], 1'b0);
        stream_q.delete();
        clear_mon();
        reset = 1'b1;
        tick();
        check_rst("t6_blk");
        reset = 1'b0;
        exp_nonce = '0;
        repeat (10) tick();
        check_eq("t6_blk.pulses", {n_start, n_done, n_err, n_tmo, n_mrst}, 160'h0);

        // Reset while the engine is running an unreachable job.
        build_frame(0, 8'h00, {$urandom, $urandom, $urandom}, 9'h000);
        clear_mon();
        foreach (stream_q[j]) send_byte(stream_q[j], 1'b0);
        stream_q.delete();
        g = 0;
        while (n_start == 0 && g < 20) begin tick(); g++; end
        check_eq("t6_wait.started", n_start, 1);
        repeat (5) tick();
        clear_mon();
        reset = 1'b1;
        tick();
        check_rst("t6_wait");
        reset = 1'b0;
        repeat (TMO + 10) tick();
        check_eq("t6_wait.pulses", {n_start, n_done, n_err, n_tmo, n_mrst}, 160'h0);
        check_eq("t6_wait.busy", busy, 1'b0);

        build_frame(1, 8'hF0, {$urandom, $urandom, $urandom}, 9'h000);
        run_case("t7_final", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
